// File: rtl/tag_dispatcher.sv
// Global-bus dispatch stage: loads per-column TAGs with a one-cycle flush, then broadcasts ID-tagged words
// until every matching column is READY. Optional drop counter enabled by `define TAG_DISPATCHER_DROP_CNT_EN.
module tag_dispatcher #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int ID_W       = $clog2(NUM_COL)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_start,
  input  logic [NUM_COL*ID_W-1:0] cfg_tags,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ID_W-1:0]         in_id,
  input  logic                    in_last,
  output logic [DATA_WIDTH-1:0]   bus_data,
  output logic [ID_W-1:0]         bus_id,
  output logic                    bus_en,
  output logic                    bus_flush,
  output logic [NUM_COL*ID_W-1:0] bus_tag,
  input  logic [NUM_COL-1:0]      col_ready,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             drop_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]              state;
  logic [NUM_COL*ID_W-1:0] tag_r;
  logic                    vld_p0;
  logic [DATA_WIDTH-1:0]   data_p0;
  logic [ID_W-1:0]         id_p0;
  logic                    last_p0;

  logic [NUM_COL-1:0]      mask;
  logic                    deliver;
  logic                    accept;

  always_comb begin
    mask = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      mask[c] = (tag_r[c*ID_W +: ID_W] == id_p0);
    end
  end

  // An empty mask delivers immediately, so unmatched words never stall the bus.
  assign deliver  = vld_p0 & ((col_ready & mask) == mask);
  assign in_ready = (state == ST_STREAM) & (~vld_p0 | deliver) & ~(deliver & last_p0);
  assign accept   = in_valid & in_ready;

  assign bus_en    = vld_p0;
  assign bus_data  = data_p0;
  assign bus_id    = id_p0;
  assign bus_flush = (state == ST_FLUSH);
  assign bus_tag   = tag_r;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      tag_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            tag_r <= cfg_tags;
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH:  state <= ST_STREAM;
        ST_STREAM: if (deliver && last_p0) state <= ST_DONE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Output register stage p0: the word currently broadcast on the bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      id_p0   <= '0;
      last_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      data_p0 <= in_data;
      id_p0   <= in_id;
      last_p0 <= in_last;
    end else if (deliver) begin
      vld_p0  <= 1'b0;
    end
  end

`ifdef TAG_DISPATCHER_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        drop_evt;
  logic [15:0] drop_cnt_r;

  assign drop_evt   = deliver & (mask == '0);
  assign drop_count = drop_cnt_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_r <= '0;
    end else if (drop_evt) begin
      drop_cnt_r <= sat_inc16(drop_cnt_r);
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_tag_dispatcher.sv
// Directed self-checking bench for tag_dispatcher: flush, streaming, stalls, duplicate tags, drops, reset.
module tb_tag_dispatcher;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int IW = 2;
`ifdef TAG_DISPATCHER_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_start;
  logic [NC*IW-1:0] cfg_tags;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_id;
  logic          in_last;
  logic [DW-1:0] bus_data;
  logic [IW-1:0] bus_id;
  logic          bus_en;
  logic          bus_flush;
  logic [NC*IW-1:0] bus_tag;
  logic [NC-1:0] col_ready;
  logic          busy;
  logic          done;
  logic [15:0]   drop_count;

  int checks = 0;
  int errors = 0;
  logic [4:0] ctrl;

  always #5 clk = ~clk;
  assign ctrl = {bus_flush, bus_en, busy, in_ready, done};

  tag_dispatcher #(.DATA_WIDTH(DW), .NUM_COL(NC), .ID_W(IW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_tags(cfg_tags),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_id(in_id),
    .in_last(in_last), .bus_data(bus_data), .bus_id(bus_id), .bus_en(bus_en),
    .bus_flush(bus_flush), .bus_tag(bus_tag), .col_ready(col_ready), .busy(busy),
    .done(done), .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [NC*IW-1:0] tags);
    cfg_tags  = tags;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_start = 1'b0; cfg_tags = '0; in_valid = 1'b0;
    in_data = '0; in_id = '0; in_last = 1'b0; col_ready = '0;
    #3;
    checks++; if (ctrl !== 5'b00000) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 5'b00000); end
    checks++; if ({bus_data, bus_id, bus_tag} !== '0) begin errors++; $display("FAIL reset_bus: data %h id %h tag %h expected all 0", bus_data, bus_id, bus_tag); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    tick();
  endtask

  task automatic test_config();
    cfg_tags  = 8'hE4;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_tags  = 8'h00;
    #1;
    checks++; if (ctrl !== 5'b10100) begin errors++; $display("FAIL flush_ctrl: got %b expected %b", ctrl, 5'b10100); end
    checks++; if (bus_tag !== 8'hE4) begin errors++; $display("FAIL flush_tag: got %h expected e4", bus_tag); end
    tick();
    checks++; if (ctrl !== 5'b00110) begin errors++; $display("FAIL stream_entry: got %b expected %b", ctrl, 5'b00110); end
    checks++; if (bus_tag !== 8'hE4) begin errors++; $display("FAIL stream_tag: got %h expected e4", bus_tag); end
  endtask

  task automatic test_stream();
    col_ready = 4'b1111;
    in_valid = 1'b1; in_data = 16'h00AA; in_id = 2'd1; in_last = 1'b0;
    tick();
    in_data = 16'h00BB; in_id = 2'd2; in_last = 1'b1;
    #1;
    checks++; if (ctrl !== 5'b01110) begin errors++; $display("FAIL stream_w0_ctrl: got %b expected %b", ctrl, 5'b01110); end
    checks++; if ({bus_data, bus_id} !== {16'h00AA, 2'd1}) begin errors++; $display("FAIL stream_w0_bus: got %h/%0d expected 00aa/1", bus_data, bus_id); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (ctrl !== 5'b01100) begin errors++; $display("FAIL stream_last_ctrl: got %b expected %b", ctrl, 5'b01100); end
    checks++; if ({bus_data, bus_id} !== {16'h00BB, 2'd2}) begin errors++; $display("FAIL stream_w1_bus: got %h/%0d expected 00bb/2", bus_data, bus_id); end
    tick();
    checks++; if (ctrl !== 5'b00101) begin errors++; $display("FAIL stream_done: got %b expected %b", ctrl, 5'b00101); end
    tick();
    checks++; if (ctrl !== 5'b00000) begin errors++; $display("FAIL stream_idle: got %b expected %b", ctrl, 5'b00000); end
    checks++; if (bus_tag !== 8'hE4) begin errors++; $display("FAIL idle_tag_hold: got %h expected e4", bus_tag); end
  endtask

  task automatic test_back_to_back_stall();
    start_xfer(8'hE4);
    col_ready = 4'b1011;
    in_valid = 1'b1; in_data = 16'h00CC; in_id = 2'd2; in_last = 1'b0;
    tick();
    in_data = 16'h00DD; in_id = 2'd0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({bus_en, in_ready, bus_data} !== {2'b10, 16'h00CC}) begin errors++; $display("FAIL stall_cyc%0d: en/rdy %b%b data %h expected 10 00cc", i + 1, bus_en, in_ready, bus_data); end
      tick();
    end
    col_ready = 4'b0100;
    #1;
    checks++; if ({bus_en, in_ready, bus_data} !== {2'b11, 16'h00CC}) begin errors++; $display("FAIL stall_cyc4: en/rdy %b%b data %h expected 11 00cc", bus_en, in_ready, bus_data); end
    tick();
    in_valid = 1'b0;
    col_ready = 4'b1111;
    #1;
    checks++; if ({bus_en, in_ready, bus_data, bus_id} !== {2'b10, 16'h00DD, 2'd0}) begin errors++; $display("FAIL stall_next: en/rdy %b%b data %h id %0d expected 10 00dd 0", bus_en, in_ready, bus_data, bus_id); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_dup_tags();
    start_xfer(8'h50);
    checks++; if (bus_tag !== 8'h50) begin errors++; $display("FAIL dup_tag: got %h expected 50", bus_tag); end
    col_ready = 4'b0100;
    in_valid = 1'b1; in_data = 16'h0011; in_id = 2'd1; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if ({bus_en, done, bus_data} !== {2'b10, 16'h0011}) begin errors++; $display("FAIL dup_col2_only: en/done %b%b data %h expected 10 0011", bus_en, done, bus_data); end
    col_ready = 4'b1000;
    tick();
    checks++; if ({bus_en, done} !== 2'b10) begin errors++; $display("FAIL dup_col3_only: en/done %b%b expected 10", bus_en, done); end
    col_ready = 4'b1100;
    tick();
    checks++; if ({bus_en, done} !== 2'b01) begin errors++; $display("FAIL dup_both: en/done %b%b expected 01", bus_en, done); end
    tick();
  endtask

  task automatic test_drop();
    start_xfer(8'h00);
    col_ready = 4'b0000;
    in_valid = 1'b1; in_data = 16'h0033; in_id = 2'd3; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if ({bus_en, in_ready, bus_id} !== {2'b11, 2'd3}) begin errors++; $display("FAIL drop_first_cycle: en/rdy %b%b id %0d expected 11 3", bus_en, in_ready, bus_id); end
    tick();
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL drop_gone: bus_en %b expected 0", bus_en); end
    checks++; if (drop_count !== EXP_DROP) begin errors++; $display("FAIL drop_count: got %0d expected %0d", drop_count, EXP_DROP); end
    in_valid = 1'b1; in_data = 16'h0044; in_id = 2'd0; in_last = 1'b1;
    col_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL drop_xfer_done: got %b expected 1", done); end
    tick();
    checks++; if ({busy, drop_count} !== {1'b0, EXP_DROP}) begin errors++; $display("FAIL drop_persist: busy %b count %0d expected 0 %0d", busy, drop_count, EXP_DROP); end
  endtask

  task automatic test_reset_mid();
    start_xfer(8'hE4);
    col_ready = 4'b0000;
    in_valid = 1'b1; in_data = 16'h0055; in_id = 2'd1; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (ctrl !== 5'b01100) begin errors++; $display("FAIL rstmid_pending: got %b expected %b", ctrl, 5'b01100); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (ctrl !== 5'b00000) begin errors++; $display("FAIL rstmid_ctrl: got %b expected %b", ctrl, 5'b00000); end
    checks++; if ({bus_data, bus_tag, drop_count} !== '0) begin errors++; $display("FAIL rstmid_regs: data %h tag %h drop %0d expected 0", bus_data, bus_tag, drop_count); end
    #2 rstn = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 16'h0066; in_id = 2'd0; in_last = 1'b0;
    tick();
    tick();
    checks++; if ({ctrl, bus_data} !== {5'b00000, 16'h0000}) begin errors++; $display("FAIL post_rst_idle: ctrl %b data %h expected 00000 0000", ctrl, bus_data); end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_config();
    test_stream();
    test_back_to_back_stall();
    test_dup_tags();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tag_dispatcher.md
Name: tag_dispatcher

Overview:
- Global-bus dispatch stage directly upstream of the PE multicaster array. Feeds all NUM_COL multicasters of one bus row.
- Loads a per-column TAG set into the casters with a one-cycle flush, then streams words from the buffer side, each carrying a destination ID, as a broadcast.
- Holds each word until every column whose TAG equals the word's ID has signalled READY, then advances to the next word.

Parameters:
- DATA_WIDTH, 16, payload width.
- NUM_COL, 4, multicasters on the bus.
- ID_W, $clog2(NUM_COL), width of ID and TAG fields.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- cfg_start  in  1  pulse: latch cfg_tags and begin a transfer
- cfg_tags  in  NUM_COL*ID_W  per-column TAG; column c uses bits [c*ID_W +: ID_W]
- in_valid  in  1  buffer word valid
- in_ready  out  1  dispatcher accepts word
- in_data  in  DATA_WIDTH  payload
- in_id  in  ID_W  destination ID
- in_last  in  1  final word of transfer
- bus_data  out  DATA_WIDTH  broadcast payload
- bus_id  out  ID_W  broadcast ID
- bus_en  out  1  CASTER_EN; word on bus is live
- bus_flush  out  1  TAG load strobe
- bus_tag  out  NUM_COL*ID_W  per-column TAG driven to casters
- col_ready  in  NUM_COL  READY from each multicaster
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of transfer
- drop_count  out  16  unmatched-word counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, tag register 0, pending flag 0. Asynchronous assertion; synchronous release is taken at the next clk edge.
- Reset asserted mid-transfer: the pending word is discarded and the FSM returns to IDLE. No done pulse is issued.
- FSM states:
  - IDLE: waits for cfg_start.
  - FLUSH: exactly 1 cycle.
  - STREAM: accepts and dispatches words.
  - DONE: exactly 1 cycle.
- IDLE→FLUSH on cfg_start. cfg_tags is latched into the tag register on that edge. cfg_start is ignored in every state other than IDLE.
- FLUSH: bus_flush=1 and bus_en=0. bus_tag = tag register, held constant in all states after FLUSH. Next state is STREAM.
- STREAM, output register:
  - One output register (pending, data, id, last). bus_en = pending. bus_data and bus_id come from the register.
  - mask[c] = (tag[c] == bus_id).
  - deliver = pending & ((col_ready & mask) == mask).
  - in_ready = (state==STREAM) & (!pending | deliver), so back-to-back words sustain 1 word/cycle.
- STREAM, handshake:
  - Latency: word accepted on edge N appears with bus_en=1 in cycle N+1. Minimum 1 cycle on the bus.
  - Accept (in_valid & in_ready) loads the register and sets pending. Deliver without accept clears pending.
  - Deliver and accept in the same cycle replace the register contents; pending stays 1.
  - bus_data and bus_id stay stable while pending & !deliver.
  - in_valid arriving while in_ready=0 is not consumed. The upstream buffer holds it.
- Empty mask (no column matches the ID): deliver=1 in the first pending cycle, the word is dropped, and drop_count increments.
- STREAM→DONE on the cycle a word with last=1 delivers. In that cycle in_ready is forced to 0.
- DONE: done=1 for that cycle. Next state is IDLE.
- Duplicate tags: all matching columns must show READY before deliver.

Optional Feature:
- Macro TAG_DISPATCHER_DROP_CNT_EN.
- Defined: drop_count is a 16-bit counter that increments on each empty-mask deliver and saturates at 0xFFFF. It clears only on reset and keeps its value across transfers.
- Undefined: drop_count is constant 0 and no counter logic is synthesized.

Test Plan:
- Reset then cfg_start with cfg_tags={3,2,1,0} (col3..col0) → bus_flush=1 for exactly one cycle, bus_tag=0xE4 from then on, busy=1.
- Words ID=1 data 0x00AA, ID=2 data 0x00BB (last), col_ready=4'b1111 constantly → one word per cycle on the bus, done pulses the cycle after 0x00BB delivers, then IDLE.
- ID=2 word with col_ready=4'b1011 for 3 cycles, then 4'b0100 → bus_data held for 4 cycles, in_ready=0 for the first 3, delivery in cycle 4.
- cfg_tags={1,1,0,0}, ID=1, col_ready toggles 4'b0100 then 4'b1100 → delivers only when both col2 and col3 are ready.
- cfg_tags={0,0,0,0}, ID=3 word → dropped after 1 cycle. drop_count=1 with the macro defined, 0 without.
- rstn low while a word is pending → bus_en=0, busy=0 and in_ready=0 immediately. After release, the FSM waits for a new cfg_start, and in_valid alone causes no bus activity.
